// File: rtl/mcycle_param.sv
// mcycle_param: WIDTH-bit multi-cycle multiply (shift-add) / divide (restoring) on magnitudes.
// Latency: WIDTH Busy cycles then a one-cycle Done; divide-by-zero skips straight to Done.
// No backpressure: the pipeline stalls on Busy. MCYCLE_EARLY_TERM_EN shortens multiplies.
module mcycle_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t             state;
  logic               is_div;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_lo;
  logic               neg_hi;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;

  always_comb begin
    sign1 = ~MCycleOp[0] & Operand1[WIDTH-1];
    sign2 = ~MCycleOp[0] & Operand2[WIDTH-1];
    mag1  = sign1 ? -Operand1 : Operand1;
    mag2  = sign2 ? -Operand2 : Operand2;
  end

  logic [2*WIDTH-1:0] acc_nxt, prod_fin;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub, rem_nxt, quo_nxt, quo_fin, rem_fin;
  logic               rem_ge;
  logic               last_iter;

  // One iteration of each algorithm, plus the sign-corrected result if it is the last.
  always_comb begin
    acc_nxt  = mplier[0] ? acc + mcand : acc;
    prod_fin = neg_lo ? -acc_nxt : acc_nxt;
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, dvsr});
    rem_sub  = rem_sh[WIDTH-1:0] - dvsr;
    rem_nxt  = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], rem_ge};
    quo_fin  = neg_lo ? -quo_nxt : quo_nxt;
    rem_fin  = neg_hi ? -rem_nxt : rem_nxt;
    last_iter = (count == CNT_W'(WIDTH - 1));
`ifdef MCYCLE_EARLY_TERM_EN
    if (!is_div && ((mplier >> 1) == '0))
      last_iter = 1'b1;
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      is_div    <= 1'b0;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      Result1   <= '0;
      Result2   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            is_div <= MCycleOp[1];
            count  <= '0;
            if (MCycleOp[1] && (Operand2 == '0)) begin
              Result1   <= '1;
              Result2   <= Operand1;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, mag1};
              mplier <= mag2;
              quo    <= mag1;
              rem    <= '0;
              dvsr   <= mag2;
              neg_lo <= sign1 ^ sign2;
              // Remainder takes the dividend's sign; product/quotient take the XOR.
              neg_hi <= MCycleOp[1] ? sign1 : (sign1 ^ sign2);
              Busy   <= 1'b1;
              state  <= S_COMPUTE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_COMPUTE: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (last_iter) begin
            Result1   <= is_div ? quo_fin : prod_fin[WIDTH-1:0];
            Result2   <= is_div ? rem_fin : prod_fin[2*WIDTH-1:WIDTH];
            DivByZero <= 1'b0;
            Done      <= 1'b1;
            Busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_param.sv
// Directed bench for mcycle_param at WIDTH=4; expected values are hand-computed.
module tb_mcycle_param;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   MCycleOp = 2'b00;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [W-1:0] Result1, Result2;
  logic         Busy, Done, DivByZero;

  int errors = 0;
  int checks = 0;

  mcycle_param #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 CLK = ~CLK;

  // Launch one op, scramble the inputs while it runs, and wait (bounded) for Done.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nbusy, output int ncyc, output bit seen_done);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    @(negedge CLK);
    Start = 1'b0; MCycleOp = ~op; Operand1 = ~a; Operand2 = ~b;
    nbusy = 0;
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) break;
      if (Busy) nbusy++;
      ncyc++;
      @(negedge CLK);
    end
    seen_done = Done;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(negedge CLK); @(negedge CLK);
    checks++; if (Result1 !== 4'b0000) begin errors++; $display("FAIL reset_r1 got %b want 0000", Result1); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL reset_r2 got %b want 0000", Result2); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", DivByZero); end
    RESET = 1'b0;
  endtask

  task automatic test_signed_mul();
    int nb, nc; bit sd;
    run_op(2'b00, 4'b1111, 4'b1111, nb, nc, sd);
    checks++; if (sd !== 1'b1) begin errors++; $display("FAIL smul_done_timeout got %b want 1", sd); end
    checks++; if (nb != 4) begin errors++; $display("FAIL smul_busy got %0d want 4", nb); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL smul_r2 got %b want 0000", Result2); end
    checks++; if (Result1 !== 4'b0001) begin errors++; $display("FAIL smul_r1 got %b want 0001", Result1); end
    checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL smul_dbz got %b want 0", DivByZero); end
    @(negedge CLK);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL smul_done_pulse got %b want 0", Done); end
    checks++; if (Result1 !== 4'b0001) begin errors++; $display("FAIL smul_r1_hold got %b want 0001", Result1); end
  endtask

  task automatic test_back_to_back();
    int nb;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 4'b1111; Operand2 = 4'b1111;
    @(negedge CLK);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) break;
      if (Busy) nb++;
      @(negedge CLK);
    end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", Done); end
    checks++; if (nb != 4) begin errors++; $display("FAIL b2b_busy1 got %0d want 4", nb); end
    checks++; if (Result2 !== 4'b1110) begin errors++; $display("FAIL b2b_r2 got %b want 1110", Result2); end
    checks++; if (Result1 !== 4'b0001) begin errors++; $display("FAIL b2b_r1 got %b want 0001", Result1); end
    @(negedge CLK);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_relaunch_busy got %b want 1", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL b2b_relaunch_done got %b want 0", Done); end
    Start = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) break;
      if (Busy) nb++;
      @(negedge CLK);
    end
    checks++; if (nb != 4) begin errors++; $display("FAIL b2b_busy2 got %0d want 4", nb); end
    checks++; if (Result2 !== 4'b1110) begin errors++; $display("FAIL b2b_r2_second got %b want 1110", Result2); end
  endtask

  task automatic test_signed_div();
    int nb, nc; bit sd;
    run_op(2'b10, 4'b0111, 4'b1111, nb, nc, sd);
    checks++; if (sd !== 1'b1) begin errors++; $display("FAIL sdiv_done_timeout got %b want 1", sd); end
    checks++; if (Result1 !== 4'b1001) begin errors++; $display("FAIL sdiv_q got %b want 1001", Result1); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL sdiv_r got %b want 0000", Result2); end
    run_op(2'b10, 4'b1000, 4'b1111, nb, nc, sd);
    checks++; if (nb != 4) begin errors++; $display("FAIL sdiv_min_busy got %0d want 4", nb); end
    checks++; if (Result1 !== 4'b1000) begin errors++; $display("FAIL sdiv_min_q got %b want 1000", Result1); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL sdiv_min_r got %b want 0000", Result2); end
  endtask

  task automatic test_unsigned_div();
    int nb, nc; bit sd;
    run_op(2'b11, 4'b0111, 4'b1111, nb, nc, sd);
    checks++; if (Result1 !== 4'b0000) begin errors++; $display("FAIL udiv_q got %b want 0000", Result1); end
    checks++; if (Result2 !== 4'b0111) begin errors++; $display("FAIL udiv_r got %b want 0111", Result2); end
    run_op(2'b11, 4'b1010, 4'b0000, nb, nc, sd);
    checks++; if (sd !== 1'b1) begin errors++; $display("FAIL dbz_done_timeout got %b want 1", sd); end
    checks++; if (nb != 0) begin errors++; $display("FAIL dbz_busy got %0d want 0", nb); end
    checks++; if (nc != 0) begin errors++; $display("FAIL dbz_latency got %0d want 0", nc); end
    checks++; if (Result1 !== 4'b1111) begin errors++; $display("FAIL dbz_r1 got %b want 1111", Result1); end
    checks++; if (Result2 !== 4'b1010) begin errors++; $display("FAIL dbz_r2 got %b want 1010", Result2); end
    checks++; if (DivByZero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", DivByZero); end
    @(negedge CLK);
    checks++; if (DivByZero !== 1'b1) begin errors++; $display("FAIL dbz_flag_hold got %b want 1", DivByZero); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL dbz_done_pulse got %b want 0", Done); end
  endtask

  task automatic test_reset_abort();
    int nb, nc; bit sd;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 4'b1111; Operand2 = 4'b1111;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", Done); end
    checks++; if (Result1 !== 4'b0000) begin errors++; $display("FAIL abort_r1 got %b want 0000", Result1); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL abort_r2 got %b want 0000", Result2); end
    checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL abort_dbz got %b want 0", DivByZero); end
    @(negedge CLK);
    RESET = 1'b0;
    run_op(2'b01, 4'b0011, 4'b0101, nb, nc, sd);
    checks++; if (nb != 4) begin errors++; $display("FAIL post_reset_busy got %0d want 4", nb); end
    checks++; if (Result1 !== 4'b1111) begin errors++; $display("FAIL post_reset_r1 got %b want 1111", Result1); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL post_reset_r2 got %b want 0000", Result2); end
  endtask

  task automatic test_mul_length();
    int nb, nc; bit sd;
`ifdef MCYCLE_EARLY_TERM_EN
    run_op(2'b01, 4'b1111, 4'b0001, nb, nc, sd);
    checks++; if (nb != 1) begin errors++; $display("FAIL early_u_busy got %0d want 1", nb); end
    checks++; if (Result1 !== 4'b1111) begin errors++; $display("FAIL early_u_r1 got %b want 1111", Result1); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL early_u_r2 got %b want 0000", Result2); end
    run_op(2'b00, 4'b0011, 4'b1110, nb, nc, sd);
    checks++; if (nb != 2) begin errors++; $display("FAIL early_s_busy got %0d want 2", nb); end
    checks++; if (Result2 !== 4'b1111) begin errors++; $display("FAIL early_s_r2 got %b want 1111", Result2); end
    checks++; if (Result1 !== 4'b1010) begin errors++; $display("FAIL early_s_r1 got %b want 1010", Result1); end
`else
    run_op(2'b01, 4'b1111, 4'b0001, nb, nc, sd);
    checks++; if (nb != 4) begin errors++; $display("FAIL full_u_busy got %0d want 4", nb); end
    checks++; if (Result1 !== 4'b1111) begin errors++; $display("FAIL full_u_r1 got %b want 1111", Result1); end
    checks++; if (Result2 !== 4'b0000) begin errors++; $display("FAIL full_u_r2 got %b want 0000", Result2); end
    run_op(2'b00, 4'b0011, 4'b1110, nb, nc, sd);
    checks++; if (nb != 4) begin errors++; $display("FAIL full_s_busy got %0d want 4", nb); end
    checks++; if (Result2 !== 4'b1111) begin errors++; $display("FAIL full_s_r2 got %b want 1111", Result2); end
    checks++; if (Result1 !== 4'b1010) begin errors++; $display("FAIL full_s_r1 got %b want 1010", Result1); end
`endif
  endtask

  initial begin
    test_reset();
    test_signed_mul();
    test_back_to_back();
    test_signed_div();
    test_unsigned_div();
    test_reset_abort();
    test_mul_length();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
